// File: rtl/axi_reset_ctrl_pkg.sv
// Shared constants and helpers for the AXI4-Lite multi-channel reset controller.
// Register offsets are word indices taken from addr[3:2].
package axi_reset_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PULSE  = 2'd1;
    localparam logic [1:0] ADDR_WIDTH  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 16;

    function automatic bit num_ch_ok(input int n);
        return (n >= NUM_CH_MIN) && (n <= NUM_CH_MAX);
    endfunction

    // Byte-lane merge: a lane with its strobe low keeps the old byte.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/reset_pulse_ch.sv
// One reset channel: a reloadable down-counter plus the registered reset output.
// The output register is fed from next-state values so a write lands one cycle after acceptance.
module reset_pulse_ch #(
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               trigger,
    input  logic [PULSE_W-1:0] width,
    input  logic               hold,
    output logic               rst_out,
    output logic               busy
);

    logic [PULSE_W-1:0] cnt_q;
    logic [PULSE_W-1:0] cnt_d;

    // A trigger always reloads, so a retrigger restarts the full width.
    always_comb begin
        cnt_d = cnt_q;
        if (trigger) begin
            cnt_d = (width == '0) ? PULSE_W'(1) : width;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PULSE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q   <= '0;
            rst_out <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            rst_out <= hold | (cnt_d != '0);
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/axi_reset_ctrl.sv
// AXI4-Lite slave with CTRL/PULSE/WIDTH/STATUS registers driving NUM_CH reset channels.
// Holds the bus handshakes and register decode; the timing lives in reset_pulse_ch.
module axi_reset_ctrl
    import axi_reset_ctrl_pkg::*;
#(
    parameter int                C_S00_AXI_DATA_WIDTH = 32,
    parameter int                C_S00_AXI_ADDR_WIDTH = 4,
    parameter int                NUM_CH               = 4,
    parameter int                PULSE_W              = 16,
    parameter logic [NUM_CH-1:0] CTRL_INIT            = '1,
    parameter int                WIDTH_INIT           = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    output logic [NUM_CH-1:0]               RESET_S,

    input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [31:0]                     s00_axi_wdata,
    input  logic [3:0]                      s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,

    input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [31:0]                     s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
);

    if (!num_ch_ok(NUM_CH) || (C_S00_AXI_DATA_WIDTH != 32)) begin : g_param_check
        $error("axi_reset_ctrl: NUM_CH must be 1..16 and data width must be 32");
    end

    // Handshake: a transfer happens in a cycle where valid and ready are both high.
    // Write: awready/wready pulse together for one cycle once both valids are seen and no
    // response is pending; bvalid then holds until bready. Read: arready pulses once per
    // arvalid while no data is pending; rvalid/rdata hold until rready.
    logic              awready_q;
    logic              bvalid_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rd_mux;
    logic              wr_fire;
    logic              rd_fire;
    logic [1:0]        wr_sel;
    logic [1:0]        rd_sel;

    logic [NUM_CH-1:0]  ctrl_q;
    logic [NUM_CH-1:0]  ctrl_d;
    logic [PULSE_W-1:0] width_q;
    logic [NUM_CH-1:0]  trigger;
    logic [NUM_CH-1:0]  busy;
    logic [31:0]        ctrl_merged;
    logic [31:0]        width_merged;

    assign wr_sel  = s00_axi_awaddr[3:2];
    assign rd_sel  = s00_axi_araddr[3:2];
    assign wr_fire = awready_q && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_fire = arready_q && s00_axi_arvalid;

    assign ctrl_merged  = strb_merge(32'(ctrl_q), s00_axi_wdata, s00_axi_wstrb);
    assign width_merged = strb_merge(32'(width_q), s00_axi_wdata, s00_axi_wstrb);

    // Channels see the post-write CTRL so a level change reaches RESET_S one cycle after acceptance.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_fire && (wr_sel == ADDR_CTRL)) begin
            ctrl_d = ctrl_merged[NUM_CH-1:0];
        end
    end

    always_comb begin
        trigger = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            trigger[i] = wr_fire && (wr_sel == ADDR_PULSE) &&
                         s00_axi_wdata[i] && s00_axi_wstrb[i/8];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            ADDR_CTRL:   rd_mux[NUM_CH-1:0]  = ctrl_q;
            ADDR_PULSE:  rd_mux[NUM_CH-1:0]  = busy;
            ADDR_WIDTH:  rd_mux[PULSE_W-1:0] = width_q;
            default: begin
                rd_mux[NUM_CH-1:0] = RESET_S;
                rd_mux[31:16]      = 16'(NUM_CH);
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            ctrl_q    <= CTRL_INIT;
            width_q   <= PULSE_W'(WIDTH_INIT);
        end else begin
            awready_q <= s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            ctrl_q <= ctrl_d;
            if (wr_fire && (wr_sel == ADDR_WIDTH)) begin
                width_q <= width_merged[PULSE_W-1:0];
            end
        end
    end

    // STATUS is captured in the arready cycle, so the read returns that cycle's RESET_S.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= s00_axi_arvalid && !arready_q && !rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        reset_pulse_ch #(
            .PULSE_W (PULSE_W)
        ) u_ch (
            .clk     (s00_axi_aclk),
            .aresetn (s00_axi_aresetn),
            .trigger (trigger[i]),
            .width   (width_q),
            .hold    (ctrl_d[i]),
            .rst_out (RESET_S[i]),
            .busy    (busy[i])
        );
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], ctrl_merged, width_merged};

endmodule
